// File: rtl/conv_enc_rsc_term.sv
// Rate-1/2 recursive systematic convolutional encoder with a valid/ready stream,
// frame delimiting and optional M-beat trellis termination back to the zero state.
module conv_enc_rsc_term #(
  parameter int             M       = 3,
  parameter logic [M-1:0]   FB_MASK = 3'b011,
  parameter logic [M-1:0]   FF_MASK = 3'b110
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       term_en,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic       s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_data,
  output logic       m_last,
  output logic       m_tail
);

  localparam int CW = $clog2(M + 1);

  typedef enum logic {RUN, TAIL} fsm_t;

  fsm_t          fsm;
  logic [M-1:0]  s;
  logic [CW-1:0] tail_cnt;

  logic load_ok;
  logic fb;
  logic in_bit;
  logic a;
  logic p;

  assign load_ok = !m_valid || m_ready;
  // Gated by rst so no beat is advertised while the encoder is held in reset.
  assign s_ready = rst && (fsm == RUN) && load_ok && !clr;

  // Tail beats feed the feedback bit back in, cancelling it so zeros shift in.
  assign fb     = ^(s & FB_MASK);
  assign in_bit = (fsm == TAIL) ? fb : s_data;
  assign a      = in_bit ^ fb;
  assign p      = a ^ (^(s & FF_MASK));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm      <= RUN;
      s        <= '0;
      tail_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= 2'b00;
      m_last   <= 1'b0;
      m_tail   <= 1'b0;
    end else if (clr) begin
      fsm      <= RUN;
      s        <= '0;
      tail_cnt <= '0;
      m_valid  <= 1'b0;
      m_data   <= 2'b00;
      m_last   <= 1'b0;
      m_tail   <= 1'b0;
    end else begin
      case (fsm)
        RUN: begin
          if (s_valid && s_ready) begin
            m_valid <= 1'b1;
            m_data  <= {p, in_bit};
            m_tail  <= 1'b0;
            if (s_last && term_en) begin
              fsm      <= TAIL;
              tail_cnt <= '0;
              m_last   <= 1'b0;
              s        <= {a, s[M-1:1]};
            end else if (s_last) begin
              m_last <= 1'b1;
              s      <= '0;
            end else begin
              m_last <= 1'b0;
              s      <= {a, s[M-1:1]};
            end
          end else if (load_ok) begin
            m_valid <= 1'b0;
          end
        end
        TAIL: begin
          if (load_ok) begin
            m_valid <= 1'b1;
            m_data  <= {p, in_bit};
            m_tail  <= 1'b1;
            s       <= {a, s[M-1:1]};
            if (tail_cnt == CW'(M - 1)) begin
              m_last   <= 1'b1;
              fsm      <= RUN;
              tail_cnt <= '0;
            end else begin
              m_last   <= 1'b0;
              tail_cnt <= tail_cnt + 1'b1;
            end
          end
        end
        default: fsm <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_rsc_term.sv
// Bench for conv_enc_rsc_term: directed frames plus randomized frames scored
// against a bit-level model of the RSC recursion.
module tb_conv_enc_rsc_term;

  localparam int           M  = 3;
  localparam logic [M-1:0] FB = 3'b011;
  localparam logic [M-1:0] FF = 3'b110;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       term_en = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_data = 1'b0;
  logic       s_last = 1'b0;
  logic       m_ready = 1'b1;
  logic       s_ready;
  logic       m_valid;
  logic [1:0] m_data;
  logic       m_last;
  logic       m_tail;

  int errors = 0;
  int checks = 0;
  int hold_bad;
  int first_xfer;
  int last_xfer;

  // input beat: {term_en, last, data}; output beat: {tail, last, parity, systematic}
  bit [2:0] in_q[$];
  bit [3:0] exp_q[$];
  bit [3:0] got_q[$];

  conv_enc_rsc_term #(.M(M), .FB_MASK(FB), .FF_MASK(FF)) dut (
    .clk(clk), .rst(rst), .clr(clr), .term_en(term_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .m_tail(m_tail)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Register st[M-1] holds the newest recursion bit; parity sums are taken over tapped cells.
  function automatic void build_model();
    int st[M];
    int u, fb, ff, a;
    bit term, last;
    bit [M-1:0] fbm, ffm;
    fbm = FB;
    ffm = FF;
    exp_q.delete();
    for (int i = 0; i < M; i++) st[i] = 0;
    foreach (in_q[n]) begin
      term = in_q[n][2];
      last = in_q[n][1];
      u    = int'(in_q[n][0]);
      for (int k = 0; k < ((last && term) ? M + 1 : 1); k++) begin
        fb = 0;
        ff = 0;
        for (int i = 0; i < M; i++) begin
          if (fbm[i]) fb = fb ^ st[i];
          if (ffm[i]) ff = ff ^ st[i];
        end
        if (k > 0) u = fb;
        a = u ^ fb;
        if (k == 0) exp_q.push_back({1'b0, last && !term, 1'(a ^ ff), 1'(u)});
        else        exp_q.push_back({1'b1, k == M, 1'(a ^ ff), 1'(u)});
        for (int i = 0; i < M - 1; i++) st[i] = st[i + 1];
        st[M-1] = a;
      end
      if (last && !term) for (int i = 0; i < M; i++) st[i] = 0;
    end
  endfunction

  // Streams in_q into the DUT and records every transferred output beat.
  task automatic collect(input int mode, input int budget);
    int idx = 0;
    int cyc = 0;
    got_q.delete();
    hold_bad   = 0;
    first_xfer = -1;
    last_xfer  = -1;
    while ((idx < in_q.size() || got_q.size() < exp_q.size()) && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = ($urandom_range(0, 9) < 7);
      endcase
      if (idx < in_q.size()) begin
        s_valid = 1'b1;
        {term_en, s_last, s_data} = in_q[idx];
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      #1;
      if (m_valid && !m_ready && s_ready) hold_bad++;
      if (m_valid && m_tail && !m_last && s_ready) hold_bad++;
      if (m_valid && m_ready) begin
        got_q.push_back({m_tail, m_last, m_data});
        if (first_xfer < 0) first_xfer = cyc;
        last_xfer = cyc;
      end
      if (s_valid && s_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (4) begin
      #1;
      if (m_valid) got_q.push_back({m_tail, m_last, m_data});
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if ({m_valid, m_data, m_last, m_tail, s_ready} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs got v=%b d=%b l=%b t=%b rdy=%b want all 0",
                 m_valid, m_data, m_last, m_tail, s_ready);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", s_ready);
    end
  endtask

  task automatic test_terminated();
    in_q  = '{3'b101, 3'b111, 3'b011};
    exp_q = '{4'b0011, 4'b0001, 4'b1001, 4'b1010, 4'b1101, 4'b0111};
    collect(0, 50);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL term_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL term_beat%0d got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp_q[i]);
      end
    end
  endtask

  task automatic test_unterminated();
    in_q  = '{3'b001, 3'b000, 3'b001, 3'b011, 3'b001, 3'b011};
    exp_q = '{4'b0011, 4'b0010, 4'b0011, 4'b0101, 4'b0011, 4'b0101};
    collect(0, 50);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL unterm_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL unterm_beat%0d got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    in_q  = '{3'b101, 3'b111};
    exp_q = '{4'b0011, 4'b0001, 4'b1001, 4'b1010, 4'b1101};
    collect(1, 80);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp_q[i]);
      end
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL bp_ready_while_held got %0d cycles want 0", hold_bad);
    end
  endtask

  task automatic test_back_to_back();
    in_q = '{3'b101, 3'b100, 3'b111, 3'b100, 3'b111};
    build_model();
    collect(0, 60);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp_q[i]);
      end
    end
    checks++;
    if (last_xfer - first_xfer + 1 !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_gapless got span %0d want %0d", last_xfer - first_xfer + 1, exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      int len;
      bit term;
      len  = $urandom_range(1, 8);
      term = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++)
        in_q.push_back({term, b == len - 1, 1'($urandom_range(0, 1))});
    end
    build_model();
    collect(2, 2000);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_beat%0d got %b want %b", i, (i < got_q.size()) ? got_q[i] : 4'bx, exp_q[i]);
      end
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL rand_ready_while_held got %0d cycles want 0", hold_bad);
    end
  endtask

  task automatic test_mid_tail_reset();
    bit found = 1'b0;
    in_q.delete();
    @(negedge clk);
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0; term_en = 1'b1;
    @(negedge clk);
    s_last = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      #1;
      if (m_valid && m_tail) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midtail_first_tail got none want tail beat");
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_data, m_last, m_tail, s_ready} !== 6'b0) begin
      errors++;
      $display("FAIL midtail_async_reset got v=%b d=%b l=%b t=%b rdy=%b want all 0",
               m_valid, m_data, m_last, m_tail, s_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    in_q  = '{3'b011};
    exp_q = '{4'b0111};
    collect(0, 20);
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 4'b0111) begin
      errors++;
      $display("FAIL midtail_restart got n=%0d beat=%b want n=1 beat=0111",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 4'bx);
    end
  endtask

  task automatic test_clr();
    @(negedge clk);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 1'b1; s_last = 1'b0; term_en = 1'b0;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_stalled got v=%b rdy=%b want v=1 rdy=0", m_valid, s_ready);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_flush got v=%b rdy=%b want v=0 rdy=1", m_valid, s_ready);
    end
    in_q  = '{3'b001, 3'b011};
    exp_q = '{4'b0011, 4'b0101};
    collect(0, 20);
    checks++;
    if (got_q.size() !== 2 || got_q[0] !== 4'b0011 || got_q[1] !== 4'b0101) begin
      errors++;
      $display("FAIL clr_restart got n=%0d b0=%b b1=%b want n=2 0011 0101", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 4'bx, (got_q.size() > 1) ? got_q[1] : 4'bx);
    end
  endtask

  initial begin
    test_reset();
    test_terminated();
    test_unterminated();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_tail_reset();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_enc_rsc_term.md
Name: conv_enc_rsc_term

Overview:
- Parametrised recursive systematic convolutional (RSC) encoder, rate 1/2, with configurable constraint length and generator masks.
- Successor to the fixed K=4 encoder. Adds a valid/ready stream interface with backpressure, frame delimiting, and optional trellis termination: M tail bits drive the state to zero after each frame.
- Sits between the frame source and the channel/Viterbi decoder path.

Parameters:
- M, 3, encoder memory (constraint length K = M+1); legal range 2..8.
- FB_MASK, 3'b011, M-bit feedback tap mask over state s[M-1:0].
- FF_MASK, 3'b110, M-bit feed-forward parity tap mask over s[M-1:0].

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- clr  in  1  synchronous flush: state, FSM and output register to reset values
- term_en  in  1  1 = append M tail beats per frame; sampled on the accepted s_last beat
- s_valid  in  1  input beat valid
- s_ready  out  1  encoder can accept an input beat
- s_data  in  1  information bit
- s_last  in  1  last information bit of frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts output beat
- m_data  out  2  [0] systematic bit, [1] parity bit
- m_last  out  1  final beat of encoded frame (last tail beat, or last data beat if no termination)
- m_tail  out  1  beat is a tail (termination) beat

Behaviour:
- Reset is asynchronous, active-low, on rst; clock clk. While rst=0: s = 0, FSM = RUN, tail_cnt = 0, m_valid = 0, m_data = 2'b00, m_last = 0, m_tail = 0. clr=1 has the same effect synchronously and overrides all other activity that cycle.
- Encoder arithmetic (per encoded bit u):
  - fb = ^(s & FB_MASK)
  - a = u ^ fb
  - p = a ^ ^(s & FF_MASK)
  - next s = {a, s[M-1:1]}
  - beat = {p, u}
- Output register is loadable when (!m_valid || m_ready). A beat transfers when m_valid && m_ready.
- s_ready = (FSM==RUN) && (!m_valid || m_ready) && !clr. It is combinational from m_valid, m_ready and FSM; no path from s_valid.
- Latency: an accepted input beat appears on m_data the next cycle. Throughput is 1 beat/cycle with m_ready held high.
- FSM state RUN, on an accepted beat (s_valid && s_ready):
  - Encode u = s_data. Load m_data, m_valid = 1, m_tail = 0.
  - If s_last && term_en: go to TAIL with tail_cnt = 0; m_last = 0.
  - If s_last && !term_en: m_last = 1; s forced to 0 (no tail); stay in RUN.
  - Otherwise m_last = 0.
- In RUN with no accepted beat: if the output register is loadable, m_valid is cleared to 0.
- FSM state TAIL, whenever the output register is loadable:
  - Encode u = fb, so a = 0. Load m_data, m_valid = 1, m_tail = 1; tail_cnt++.
  - On the beat with tail_cnt == M-1: m_last = 1, go to RUN.
  - After M tail beats, s == 0 is guaranteed.
  - s_ready = 0 throughout TAIL.
- Backpressure: while m_valid && !m_ready, m_data/m_last/m_tail hold stable, s holds, tail_cnt holds.
- Frames are back-to-back capable: a new frame's first beat may be accepted in the same cycle the final tail beat transfers.
- Reset or clr mid-frame or mid-TAIL discards the partial frame. No m_last is emitted for it, and the next frame starts from s = 0.

Test Plan:
- Reset: hold rst=0 with s_valid=1 -> m_valid=0, m_data=00, s_ready=0 until after release; state encodes from 000.
- Terminated frame: defaults, term_en=1, m_ready=1, bits 1,1(last) -> m_data 11,01 then tail 01,10,01; m_tail=1 on the last 3 beats; m_last only on the 5th; next frame bit 1 -> 11.
- Unterminated frame: term_en=0, bits 1,0,1,1(last) -> 11,10,11,01 with m_last on the 4th; next frame bits 1,1 -> 11,01 (state restarted at 000).
- Backpressure: terminated frame 1,1 with m_ready toggling 1,0,0,1,... -> identical sequence 11,01,01,10,01 with no loss or duplication; s_ready=0 during TAIL and whenever output is held.
- Mid-tail reset: assert rst=0 after the first tail beat -> outputs return to reset values immediately; post-release frame bit 1 -> 11, no stray m_last or m_tail.
- Sync clr: pulse clr during a stalled beat (m_ready=0) -> next cycle m_valid=0, s=0, FSM=RUN, s_ready reasserted.
